// File: rtl/seg7_word_receiver.sv
// Receives active-low seven-segment patterns one digit at a time and assembles
// four hex digits into a 16-bit word, with a ready/valid handshake on each side.
module seg7_word_receiver (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg_in,
    input  logic        seg_valid,
    output logic        seg_ready,
    output logic [15:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [1:0]  digit_idx,
    output logic        err_pulse,
    output logic [7:0]  err_count
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        seg_ready_r;
    logic [15:0] word_r;
    logic        word_valid_r;
    logic [1:0]  digit_idx_r;
    logic        err_pulse_r;
    logic [7:0]  err_count_r;

    logic [4:0]  decode_s;
    logic        digit_ok_s;
    logic [3:0]  nibble_s;
    logic        accept_s;

    // Returns {recognised, nibble}; bit order of seg is g..a (bit6..bit0).
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'b1000000: decode_seg = 5'b1_0000;
            7'b1111001: decode_seg = 5'b1_0001;
            7'b0100100: decode_seg = 5'b1_0010;
            7'b0110000: decode_seg = 5'b1_0011;
            7'b0011001: decode_seg = 5'b1_0100;
            7'b0010010: decode_seg = 5'b1_0101;
            7'b0000010: decode_seg = 5'b1_0110;
            7'b1111000: decode_seg = 5'b1_0111;
            7'b0000000: decode_seg = 5'b1_1000;
            7'b0010000: decode_seg = 5'b1_1001;
            7'b0001000: decode_seg = 5'b1_1010;
            7'b0000011: decode_seg = 5'b1_1011;
            7'b1000110: decode_seg = 5'b1_1100;
            7'b0100001: decode_seg = 5'b1_1101;
            7'b0000110: decode_seg = 5'b1_1110;
            7'b0001110: decode_seg = 5'b1_1111;
            default:    decode_seg = 5'b0_0000;
        endcase
    endfunction

    assign decode_s   = decode_seg(seg_in);
    assign digit_ok_s = decode_s[4];
    assign nibble_s   = decode_s[3:0];
    // seg_ready_r is high exactly in COLLECT, so this is the transfer qualifier.
    assign accept_s   = seg_valid & seg_ready_r;

    // Next-state decode for the collect/hold controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            COLLECT: begin
                if (accept_s && digit_ok_s && (digit_idx_r == 2'd3)) begin
                    state_s = HOLD;
                end else begin
                    state_s = COLLECT;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    state_s = COLLECT;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= COLLECT;
        end else begin
            state_r <= state_s;
        end
    end

    // Word assembly, handshake flags and error bookkeeping, all registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_ready_r  <= 1'b1;
            word_r       <= 16'h0000;
            word_valid_r <= 1'b0;
            digit_idx_r  <= 2'd0;
            err_pulse_r  <= 1'b0;
            err_count_r  <= 8'd0;
        end else begin
            seg_ready_r  <= (state_s == COLLECT);
            word_valid_r <= (state_s == HOLD);
            err_pulse_r  <= accept_s & ~digit_ok_s;
            if (accept_s && digit_ok_s) begin
                word_r      <= {word_r[11:0], nibble_s};
                // Wraps 3 -> 0 as the fourth digit completes the word.
                digit_idx_r <= digit_idx_r + 2'd1;
            end else if (accept_s) begin
                digit_idx_r <= 2'd0;
                if (err_count_r != 8'hFF) begin
                    err_count_r <= err_count_r + 8'd1;
                end
            end
        end
    end

    assign seg_ready  = seg_ready_r;
    assign word_out   = word_r;
    assign word_valid = word_valid_r;
    assign digit_idx  = digit_idx_r;
    assign err_pulse  = err_pulse_r;
    assign err_count  = err_count_r;

endmodule

// File: tb/tb_seg7_word_receiver.sv
// Directed bench for seg7_word_receiver: word assembly, hold/handshake,
// error handling with saturation, and reset priority.
module tb_seg7_word_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg_in;
    logic        seg_valid;
    logic        seg_ready;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [1:0]  digit_idx;
    logic        err_pulse;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PA = 7'b0001000;
    localparam logic [6:0] PB = 7'b0000011;
    localparam logic [6:0] PC = 7'b1000110;
    localparam logic [6:0] PE = 7'b0000110;
    localparam logic [6:0] BAD1 = 7'b1111111;
    localparam logic [6:0] BAD2 = 7'b0110110;

    seg7_word_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (seg_in),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .digit_idx  (digit_idx),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [6:0] pat);
        seg_in    = pat;
        seg_valid = 1'b1;
        tick();
        seg_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, {31'd0, seg_ready}, 32'd1);
        chk({tag, "_word"}, {16'd0, word_out}, 32'h0000);
        chk({tag, "_wvalid"}, {31'd0, word_valid}, 32'd0);
        chk({tag, "_idx"}, {30'd0, digit_idx}, 32'd0);
        chk({tag, "_errp"}, {31'd0, err_pulse}, 32'd0);
        chk({tag, "_errc"}, {24'd0, err_count}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; seg_in = 7'd0; seg_valid = 1'b0; word_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk_reset_state("por");

        // Four back-to-back digits 5 b C E.
        seg_valid = 1'b1;
        seg_in = P5; tick();
        chk("d1_idx", {30'd0, digit_idx}, 32'd1);
        chk("d1_word", {16'd0, word_out}, 32'h0005);
        seg_in = PB; tick();
        seg_in = PC; tick();
        chk("d3_idx", {30'd0, digit_idx}, 32'd3);
        chk("d3_wvalid", {31'd0, word_valid}, 32'd0);
        seg_in = PE; tick();
        chk("w1_word", {16'd0, word_out}, 32'h5BCE);
        chk("w1_wvalid", {31'd0, word_valid}, 32'd1);
        chk("w1_ready", {31'd0, seg_ready}, 32'd0);
        chk("w1_idx", {30'd0, digit_idx}, 32'd0);

        // Hold for 10 cycles with random traffic on the segment side.
        for (int i = 0; i < 10; i++) begin
            seg_in = 7'($urandom_range(0, 127));
            seg_valid = 1'b1;
            tick();
            chk("hold_word", {16'd0, word_out}, 32'h5BCE);
            chk("hold_wvalid", {31'd0, word_valid}, 32'd1);
            chk("hold_errc", {24'd0, err_count}, 32'd0);
            chk("hold_idx", {30'd0, digit_idx}, 32'd0);
        end
        // Handshake cycle: a digit offered here must be ignored.
        seg_in = P1; seg_valid = 1'b1; word_ready = 1'b1;
        chk("hs_ready_low", {31'd0, seg_ready}, 32'd0);
        tick();
        word_ready = 1'b0; seg_valid = 1'b0;
        chk("hs_wvalid", {31'd0, word_valid}, 32'd0);
        chk("hs_ready", {31'd0, seg_ready}, 32'd1);
        chk("hs_idx", {30'd0, digit_idx}, 32'd0);
        chk("hs_word", {16'd0, word_out}, 32'h5BCE);

        // word_ready while idle has no effect; a bubble keeps idx.
        word_ready = 1'b1; tick(); word_ready = 1'b0;
        chk("idle_wr_ready", {31'd0, seg_ready}, 32'd1);
        send(P1);
        tick();
        chk("bubble_idx", {30'd0, digit_idx}, 32'd1);
        send(P2);
        chk("d12_word", {16'd0, word_out}, 32'hCE12);
        send(BAD1);
        chk("bad_errp", {31'd0, err_pulse}, 32'd1);
        chk("bad_errc", {24'd0, err_count}, 32'd1);
        chk("bad_idx", {30'd0, digit_idx}, 32'd0);
        chk("bad_word", {16'd0, word_out}, 32'hCE12);
        seg_valid = 1'b1;
        seg_in = P7; tick();
        chk("errp_one_cycle", {31'd0, err_pulse}, 32'd0);
        seg_in = P8; tick();
        seg_in = P9; tick();
        seg_in = PA; tick();
        seg_valid = 1'b0;
        chk("w2_word", {16'd0, word_out}, 32'h789A);
        chk("w2_wvalid", {31'd0, word_valid}, 32'd1);
        word_ready = 1'b1; tick(); word_ready = 1'b0;
        chk("w2_release", {31'd0, seg_ready}, 32'd1);

        // 300 invalid patterns: pulse each time, count saturates at 255.
        seg_valid = 1'b1; seg_in = BAD2;
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("sat_errp", {31'd0, err_pulse}, 32'd1);
            if (i == 253) chk("sat_errc_254", {24'd0, err_count}, 32'd255);
        end
        seg_valid = 1'b0;
        chk("sat_errc", {24'd0, err_count}, 32'd255);
        chk("sat_word", {16'd0, word_out}, 32'h789A);
        tick();
        chk("sat_errp_off", {31'd0, err_pulse}, 32'd0);

        // Reset after two digits, coinciding with a digit accept.
        send(P0); send(P0);
        seg_in = P3; seg_valid = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; seg_valid = 1'b0;
        chk_reset_state("rst_mid");

        // Reset during HOLD, coinciding with word_ready.
        send(P1); send(P2); send(P3); send(P4);
        chk("w3_word", {16'd0, word_out}, 32'h1234);
        chk("w3_wvalid", {31'd0, word_valid}, 32'd1);
        reset = 1'b1; word_ready = 1'b1;
        tick();
        reset = 1'b0; word_ready = 1'b0;
        chk_reset_state("rst_hold");

        send(P0); send(P0); send(P0); send(P1);
        chk("w4_word", {16'd0, word_out}, 32'h0001);
        chk("w4_wvalid", {31'd0, word_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_word_receiver.md
SEG7_WORD_RECEIVER -- requirements
Module: seg7_word_receiver

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 seg_in  input  7  active-low segment pattern, bit0=a .. bit6=g.
REQ-005 seg_valid  input  1  seg_in holds a pattern this cycle.
REQ-006 seg_ready  output  1  block accepts a pattern this cycle.
REQ-007 word_out  output  16  assembled word of four hex digits.
REQ-008 word_valid  output  1  word_out is valid and held.
REQ-009 word_ready  input  1  consumer accepts word_out this cycle.
REQ-010 digit_idx  output  2  number of digits collected in the current word.
REQ-011 err_pulse  output  1  one-cycle flag for an unrecognised pattern.
REQ-012 err_count  output  8  count of unrecognised patterns, saturating.

Function
REQ-013 SHALL map seg_in (bit6..bit0) to a nibble as follows: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-014 SHALL treat any other 7-bit value as invalid.
REQ-015 SHALL implement FSM states COLLECT and HOLD, and SHALL enter COLLECT with digit_idx=0 on reset.
REQ-016 SHALL drive seg_ready=1 in COLLECT and seg_ready=0 in HOLD.
REQ-017 SHALL count a transfer as accepted only on a cycle with seg_valid=1 and seg_ready=1.
REQ-018 SHALL shift each accepted valid digit into the word MSB-first: first digit becomes word_out[15:12], fourth digit becomes word_out[3:0].
REQ-019 SHALL increment digit_idx on each accepted valid digit in COLLECT.
REQ-020 SHALL, on the accepted fourth digit (digit_idx=3), move to HOLD and assert word_valid on the next cycle (latency 1), with digit_idx returning to 0.
REQ-021 SHALL hold word_out and word_valid stable in HOLD until word_ready=1.
REQ-022 SHALL, in HOLD with word_ready=1, deassert word_valid and return to COLLECT on the next cycle; seg_ready SHALL be 1 in that next cycle, not in the handshake cycle.
REQ-023 SHALL ignore word_ready while word_valid=0.
REQ-024 SHALL, on an accepted invalid pattern, discard the partial word and set digit_idx to 0.
REQ-025 SHALL, on an accepted invalid pattern, assert err_pulse for exactly the following cycle.
REQ-026 SHALL, on an accepted invalid pattern, increment err_count, saturating at 255.
REQ-027 SHALL leave word_out unchanged on an invalid pattern; word_out SHALL update only when a new digit is accepted.
REQ-028 SHALL ignore seg_in and seg_valid in HOLD: no error is counted and no state changes.
REQ-029 SHALL allow back-to-back accepted digits on consecutive cycles with no bubbles in COLLECT.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, force state=COLLECT, word_out=0, word_valid=0, digit_idx=0, err_pulse=0, err_count=0, so that seg_ready=1 in the following cycle.
REQ-031 SHALL give reset priority over every simultaneous event, including a digit accept or word_ready, and SHALL discard any partial or held word.

Verification
REQ-032 Sequence 0010010, 0000011, 1000110, 0000110 on four consecutive valid cycles -> word_out=0x5BCE with word_valid=1 one cycle after the fourth digit, and seg_ready=0.
REQ-033 word_ready held 0 for 10 cycles in HOLD with seg_valid=1 and random seg_in -> word_out stays 0x5BCE, err_count unchanged; word_ready=1 -> word_valid=0 and seg_ready=1 on the next cycle.
REQ-034 Digits 1, 2, then 1111111 -> err_pulse high for one cycle, err_count=1, digit_idx=0; then 7, 8, 9, A -> word_out=0x789A.
REQ-035 300 invalid patterns (e.g. 0110110) -> err_count saturates at 255; err_pulse asserts for each one.
REQ-036 Reset asserted after two digits, and again during HOLD -> all outputs return to reset values; the next four digits 0, 0, 0, 1 give word_out=0x0001.
